// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub/accumulate block.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam int LIMIT_W = 64;

  // Signed max (neg=0) or min (neg=1) of a w-bit word, sign-extended to LIMIT_W bits.
  function automatic logic [LIMIT_W-1:0] signed_limit(input int w, input logic neg);
    logic [LIMIT_W-1:0] smax;
    smax = (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
    return neg ? ~smax : smax;
  endfunction

endpackage

// File: rtl/addsub_accum_if.sv
// Operand/result handshake bundle between the operand source, the block and the output mux.
interface addsub_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             ovf_sticky;
  logic [CNT_W-1:0] acc_count;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow, ovf_sticky, acc_count
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow, ovf_sticky, acc_count
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational arithmetic: add/sub/accumulate/load with carry, signed overflow and optional clamping.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam logic [LIMIT_W-1:0] SMAX_FULL = signed_limit(WIDTH, 1'b0);
  localparam logic [LIMIT_W-1:0] SMIN_FULL = signed_limit(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0]   SMAX      = SMAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   SMIN      = SMIN_FULL[WIDTH-1:0];

  // On overflow the true result always has the sign of the first operand.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                input logic ovf, input logic neg);
    if (SATURATE != 0 && ovf) return neg ? SMIN : SMAX;
    return wrapped;
  endfunction

  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] y;
  logic        [WIDTH:0]   sum;

  always_comb begin
    x       = (op_i == OP_ACC) ? acc_i : a_i;
    y       = (op_i == OP_ACC) ? a_i : b_i;
    sum     = '0;
    res_o   = a_i;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_ADD, OP_ACC: begin
        sum     = {1'b0, x} + {1'b0, y};
        carry_o = sum[WIDTH];
        ovf_o   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        res_o   = saturate(sum[WIDTH-1:0], ovf_o, x[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, x} - {1'b0, y};
        carry_o = sum[WIDTH];
        ovf_o   = (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        res_o   = saturate(sum[WIDTH-1:0], ovf_o, x[WIDTH-1]);
      end
      default: begin
        res_o   = a_i;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/addsub_accum.sv
// Registered add/sub/accumulate stage with valid/ready output, accumulator, ACC counter and sticky overflow.
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 8
) (
  input logic            clk,
  input logic            rst,
  addsub_accum_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;

  addsub_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .op_i    (bus.op),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .acc_i   (acc_q),
    .res_o   (core_res),
    .carry_o (core_carry),
    .ovf_o   (core_ovf)
  );

  // A consumed result frees the register in the same cycle, so flow never bubbles.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_res;
      carry_d     = core_carry;
      ovf_d       = core_ovf;
      if (core_ovf) sticky_d = 1'b1;
      if (bus.op == OP_LOAD) begin
        acc_d    = bus.a;
        cnt_d    = '0;
        sticky_d = 1'b0;
      end else if (bus.op == OP_ACC) begin
        acc_d = core_res;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.carry      = carry_q;
  assign bus.overflow   = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.acc_count  = cnt_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench: wrapping and saturating instances share stimulus; each result is checked on consumption.
module tb_addsub_accum;
  import addsub_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  typedef struct {
    logic [W-1:0]  r;
    logic          cy;
    logic          ov;
    logic          stk;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_accum_if #(.WIDTH(W), .CNT_W(CW)) b0 ();
  addsub_accum_if #(.WIDTH(W), .CNT_W(CW)) b1 ();

  assign b1.in_valid  = b0.in_valid;
  assign b1.op        = b0.op;
  assign b1.a         = b0.a;
  assign b1.b         = b0.b;
  assign b1.out_ready = b0.out_ready;

  addsub_accum #(.WIDTH(W), .SATURATE(0), .CNT_W(CW)) dut_wrap (.clk(clk), .rst(rst), .bus(b0));
  addsub_accum #(.WIDTH(W), .SATURATE(1), .CNT_W(CW)) dut_sat  (.clk(clk), .rst(rst), .bus(b1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t q0[$];
  exp_t q1[$];
  logic [W-1:0]  acc_m[2];
  logic [CW-1:0] cnt_m[2];
  logic          stk_m[2];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = '0;
      cnt_m[k] = '0;
      stk_m[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  task automatic model(input logic [1:0] opv, input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      longint ua, ub, sa, sb, ut, st;
      logic [W-1:0] x, y;
      x  = (opv == 2'b10) ? acc_m[k] : av;
      y  = (opv == 2'b10) ? av : bv;
      ua = longint'(x);
      ub = longint'(y);
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      if (opv == 2'b11) begin
        e.r = av; e.cy = 1'b0; e.ov = 1'b0;
        acc_m[k] = av; cnt_m[k] = '0; stk_m[k] = 1'b0;
      end else begin
        if (opv == 2'b01) begin
          ut = ua - ub; st = sa - sb; e.cy = (ua < ub);
        end else begin
          ut = ua + ub; st = sa + sb; e.cy = (ut > 255);
        end
        e.ov = (st > 127) || (st < -128);
        if (k == 1 && e.ov) e.r = (st > 0) ? 8'h7F : 8'h80;
        else                e.r = ut[W-1:0];
        if (e.ov) stk_m[k] = 1'b1;
        if (opv == 2'b10) begin
          acc_m[k] = e.r;
          if (cnt_m[k] != 8'hFF) cnt_m[k] = cnt_m[k] + 8'd1;
        end
      end
      e.stk = stk_m[k];
      e.cnt = cnt_m[k];
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [W-1:0] r, input logic cy,
                     input logic ov, input logic stk, input logic [CW-1:0] cnt);
    chk({tag, ".result"}, r, e.r);
    chk({tag, ".carry"}, cy, e.cy);
    chk({tag, ".overflow"}, ov, e.ov);
    chk({tag, ".ovf_sticky"}, stk, e.stk);
    chk({tag, ".acc_count"}, cnt, e.cnt);
  endtask

  // Monitor: a result is compared when it is consumed.
  always @(negedge clk) begin
    if (!rst) begin
      if (b0.out_valid && b0.out_ready) begin
        if (q0.size() == 0) chk("wrap.unexpected_result", 1, 0);
        else cmp("wrap", q0.pop_front(), b0.result, b0.carry, b0.overflow, b0.ovf_sticky, b0.acc_count);
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("sat.unexpected_result", 1, 0);
        else cmp("sat", q1.pop_front(), b1.result, b1.carry, b1.overflow, b1.ovf_sticky, b1.acc_count);
      end
    end
  end

  task automatic issue(input logic [1:0] opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ordy);
    int  w = 0;
    bit  done = 0;
    b0.in_valid  = 1'b1;
    b0.op        = op_e'(opv);
    b0.a         = av;
    b0.b         = bv;
    b0.out_ready = ordy;
    while (!done) begin
      @(negedge clk);
      if (b0.in_ready) begin
        model(opv, av, bv);
        done = 1;
      end else if (++w > 50) begin
        chk("accept_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) b0.out_ready = 1'b1;
    end
    b0.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, b0.out_valid, 0);
    chk({tag, ".result"}, b0.result, 0);
    chk({tag, ".flags"}, {b0.carry, b0.overflow, b0.ovf_sticky}, 0);
    chk({tag, ".acc_count"}, b0.acc_count, 0);
    chk({tag, ".sat_out_valid"}, b1.out_valid, 0);
    chk({tag, ".sat_result"}, b1.result, 0);
  endtask

  initial begin
    int c0;
    b0.in_valid  = 1'b0;
    b0.op        = OP_ADD;
    b0.a         = '0;
    b0.b         = '0;
    b0.out_ready = 1'b0;
    model_reset();

    // Reset for two cycles
    @(posedge clk); @(negedge clk);
    chk_zero("reset_first_edge");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");
    chk("after_reset.in_ready", b0.in_ready, 1);
    @(posedge clk); #1;

    // Overflow / borrow corners
    issue(2'b00, 8'h7F, 8'h01, 1'b1);
    issue(2'b01, 8'h00, 8'h01, 1'b1);
    issue(2'b01, 8'h80, 8'h01, 1'b1);
    issue(2'b00, 8'h80, 8'h80, 1'b1);
    idle(2);

    // LOAD/ACC back-to-back must stream without bubbles
    c0 = cyc;
    issue(2'b11, 8'd5, 8'd0, 1'b1);
    issue(2'b10, 8'd3, 8'd0, 1'b1);
    issue(2'b10, 8'd2, 8'd0, 1'b1);
    chk("no_bubble_cycles", cyc - c0, 3);
    @(negedge clk);
    chk("acc_chain.result", b0.result, 10);
    chk("acc_chain.acc_count", b0.acc_count, 2);
    @(posedge clk); #1;
    idle(2);

    // Backpressure: held result, then consume and accept in one cycle
    issue(2'b00, 8'd10, 8'd20, 1'b0);
    b0.in_valid = 1'b1; b0.op = OP_SUB; b0.a = 8'd50; b0.b = 8'd7; b0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.in_ready", b0.in_ready, 0);
      chk("stall.out_valid", b0.out_valid, 1);
      chk("stall.result_held", b0.result, 30);
      @(posedge clk); #1;
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    chk("release.in_ready", b0.in_ready, 1);
    model(2'b01, 8'd50, 8'd7);
    @(posedge clk); #1 b0.in_valid = 1'b0;
    @(negedge clk);
    chk("release.new_result", b0.result, 43);
    chk("release.out_valid", b0.out_valid, 1);
    @(posedge clk); #1;
    idle(2);

    // Reset in the middle of a stall with acc=0x40
    issue(2'b11, 8'h40, 8'h00, 1'b0);
    @(negedge clk);
    chk("pre_rst.in_ready", b0.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_stall_reset");
    @(posedge clk); #1;
    issue(2'b10, 8'h01, 8'h00, 1'b1);
    @(negedge clk);
    chk("post_rst_acc.result", b0.result, 1);
    chk("post_rst_acc.acc_count", b0.acc_count, 1);
    chk("post_rst_acc.ovf_sticky", b0.ovf_sticky, 0);
    @(posedge clk); #1;

    // Counter saturation
    issue(2'b11, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 260; i++) issue(2'b10, 8'h01, 8'h00, 1'b1);
    idle(2);

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      logic [1:0] opv;
      opv = 2'($urandom_range(0, 3));
      if (opv == 2'b11 && $urandom_range(0, 2) != 0) opv = 2'b10;
      issue(opv, 8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 4) == 0) begin
        b0.out_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    idle(4);
    chk("drain.wrap_queue_empty", q0.size(), 0);
    chk("drain.sat_queue_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
